// File: rtl/pic16_pkg.sv
// pic16 ICSP loader shared definitions: command codes, FSM states and
// default widths for the program memory port.
package pic16_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 14;
    localparam int CMD_W      = 6;

    localparam logic [CMD_W-1:0] CMD_LOAD_DATA  = 6'h02;
    localparam logic [CMD_W-1:0] CMD_READ_DATA  = 6'h04;
    localparam logic [CMD_W-1:0] CMD_INC_ADDR   = 6'h06;
    localparam logic [CMD_W-1:0] CMD_BEGIN_PROG = 6'h08;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_RD   = 3'd3,
        ST_PROG = 3'd4
    } state_t;

endpackage

// File: rtl/pic16_sync_edge.sv
// Multi-flop synchronizer with single-CLK rise/fall pulses.
// Ports: CLK, RST (sync, active high), d (async in), q (synced), rise, fall.
module pic16_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_r[i] <= sync_r[i-1];
            prev_r <= q;
        end
    end

    assign q    = sync_r[SYNC_STAGES-1];
    assign rise = q & ~prev_r;
    assign fall = ~q & prev_r;

endmodule

// File: rtl/pic16_icsp_loader.sv
// Serial ICSP slave writing 14-bit words into the pic16 program memory.
// Ports: CLK/RST, PGM/PGC/PGD pins, PGD_O/PGD_OE readback, IM_* write
// port + IM_RDATA, CORE_RST, BUSY. Readback under `ICSP_READBACK_EN.
module pic16_icsp_loader
    import pic16_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int PROG_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PGM,
    input  logic              PGC,
    input  logic              PGD,
    output logic              PGD_O,
    output logic              PGD_OE,
    output logic              IM_WE,
    output logic [ADDR_W-1:0] IM_ADDR,
    output logic [DATA_W-1:0] IM_WDATA,
    input  logic [DATA_W-1:0] IM_RDATA,
    output logic              CORE_RST,
    output logic              BUSY
);

    // data frame: start bit, DATA_W payload bits, stop bit
    localparam int FR_W = DATA_W + 2;

    logic pgm_q, pgm_rise, pgm_fall;
    logic pgc_q, pgc_rise, pgc_fall;
    logic [SYNC_STAGES-1:0] pgd_sync;
    logic pgd_s;

    pic16_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pgm (
        .CLK(CLK), .RST(RST), .d(PGM),
        .q(pgm_q), .rise(pgm_rise), .fall(pgm_fall)
    );

    pic16_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pgc (
        .CLK(CLK), .RST(RST), .d(PGC),
        .q(pgc_q), .rise(pgc_rise), .fall(pgc_fall)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            pgd_sync <= '0;
        end else begin
            pgd_sync[0] <= PGD;
            for (int i = 1; i < SYNC_STAGES; i++)
                pgd_sync[i] <= pgd_sync[i-1];
        end
    end
    assign pgd_s = pgd_sync[SYNC_STAGES-1];

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_r;
    logic [FR_W-2:0]   shreg;
    logic [4:0]        bit_cnt;
    logic [7:0]        busy_cnt;
    logic              im_we;
    logic              busy;

    // LSB-first shift: the newest bit always lands at the top, so after a
    // full field the field sits in the upper bits of frame.
    logic [FR_W-1:0]  frame;
    logic [CMD_W-1:0] cmd;
    assign frame = {pgd_s, shreg};
    assign cmd   = frame[FR_W-1 -: CMD_W];

`ifdef ICSP_READBACK_EN
    logic [FR_W-1:0] rd_sr;
    logic            rd_first;
    logic            pgd_o_r;
    logic            pgd_oe_r;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            addr     <= '0;
            data_r   <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            busy_cnt <= '0;
            im_we    <= 1'b0;
            busy     <= 1'b0;
`ifdef ICSP_READBACK_EN
            rd_sr    <= '0;
            rd_first <= 1'b0;
            pgd_o_r  <= 1'b0;
            pgd_oe_r <= 1'b0;
`endif
        end else if (pgm_fall && state != ST_IDLE) begin
            // abort: drop partial frame and any in-flight programming
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            busy_cnt <= '0;
            im_we    <= 1'b0;
            busy     <= 1'b0;
`ifdef ICSP_READBACK_EN
            rd_first <= 1'b0;
            pgd_o_r  <= 1'b0;
            pgd_oe_r <= 1'b0;
`endif
        end else begin
            im_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pgm_rise) begin
                        addr    <= '0;
                        bit_cnt <= '0;
                        state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (pgc_fall) begin
                        shreg <= frame[FR_W-1:1];
                        if (bit_cnt == 5'(CMD_W - 1)) begin
                            bit_cnt <= '0;
                            case (cmd)
                                CMD_LOAD_DATA: state <= ST_DATA;
`ifdef ICSP_READBACK_EN
                                CMD_READ_DATA: begin
                                    rd_first <= 1'b1;
                                    state    <= ST_RD;
                                end
`endif
                                CMD_INC_ADDR: addr <= addr + 1'b1;
                                CMD_BEGIN_PROG: begin
                                    im_we    <= 1'b1;
                                    busy     <= 1'b1;
                                    busy_cnt <= 8'(PROG_CYCLES - 1);
                                    state    <= ST_PROG;
                                end
                                default: ;
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (pgc_fall) begin
                        shreg <= frame[FR_W-1:1];
                        if (bit_cnt == 5'(FR_W - 1)) begin
                            data_r  <= frame[FR_W-2:1];
                            bit_cnt <= '0;
                            state   <= ST_CMD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef ICSP_READBACK_EN
                ST_RD: begin
                    if (rd_first) begin
                        // IM_ADDR has been stable for a full CLK here
                        rd_sr    <= {1'b0, IM_RDATA, 1'b0};
                        rd_first <= 1'b0;
                    end else begin
                        if (pgc_rise) begin
                            pgd_o_r  <= rd_sr[0];
                            rd_sr    <= {1'b0, rd_sr[FR_W-1:1]};
                            pgd_oe_r <= 1'b1;
                        end
                        if (pgc_fall) begin
                            if (bit_cnt == 5'(FR_W - 1)) begin
                                bit_cnt  <= '0;
                                pgd_o_r  <= 1'b0;
                                pgd_oe_r <= 1'b0;
                                state    <= ST_CMD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
`endif
                ST_PROG: begin
                    if (busy_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_CMD;
                    end else begin
                        busy_cnt <= busy_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign IM_WE    = im_we;
    assign IM_ADDR  = addr;
    assign IM_WDATA = data_r;
    assign BUSY     = busy;
    assign CORE_RST = (state != ST_IDLE);

`ifdef ICSP_READBACK_EN
    assign PGD_O  = pgd_o_r;
    assign PGD_OE = pgd_oe_r;
    logic unused_ok;
    assign unused_ok = ^{pgm_q, pgc_q, frame[0]};
`else
    assign PGD_O  = 1'b0;
    assign PGD_OE = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{pgm_q, pgc_q, frame[0], pgc_rise, IM_RDATA};
`endif

endmodule
